// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types: word, RAM handshake state and the
// coherence bus controller FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        DWB,
        SNOOP,
        C2C,
        MEMRD,
        IFETCH
    } ccstate_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer
// toggles on an advance pulse.
module rr_arb2 (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       adv,
    output logic       win
);

    logic ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            ptr <= 1'b0;
        else if (adv)
            ptr <= ~ptr;
    end

    // Pointer side wins on a tie; no request leaves win = ~ptr.
    always_comb win = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snoopy MSI bus controller for two cores sharing one RAM port:
// arbitration, snoops, cache-to-cache forwarding and invalidation.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int OFFBIT = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NCORES-1:0]       iREN,
    input  word_t [NCORES-1:0]      iaddr,
    output logic [NCORES-1:0]       iwait,
    output word_t [NCORES-1:0]      iload,
    input  logic [NCORES-1:0]       dREN,
    input  logic [NCORES-1:0]       dWEN,
    input  word_t [NCORES-1:0]      daddr,
    input  word_t [NCORES-1:0]      dstore,
    output logic [NCORES-1:0]       dwait,
    output word_t [NCORES-1:0]      dload,
    input  logic [NCORES-1:0]       cctrans,
    input  logic [NCORES-1:0]       ccwrite,
    output logic [NCORES-1:0]       ccwait,
    output logic [NCORES-1:0]       ccinv,
    output word_t [NCORES-1:0]      ccsnoopaddr,
    output logic                    ramREN,
    output logic                    ramWEN,
    output word_t                   ramaddr,
    output word_t                   ramstore,
    input  word_t                   ramload,
    input  ramstate_t               ramstate
);

    ccstate_t state, nstate;
    logic g, ng, o;
    logic c2c_hold, nhold;
    logic [1:0] dreq, darb;
    logic dwin, iwin, ccw;
    logic dadv, iadv;
    logic done, lastw;

    assign o     = ~g;
    assign dreq  = dREN | dWEN;
    assign done  = (ramstate == ACCESS);
    assign lastw = daddr[g][OFFBIT];
    assign iload = {NCORES{ramload}};

    // With no data request the data arbiter ranks the cctrans
    // pair, so a double write-hit is settled by rr_d.
    assign darb = (|dreq) ? dreq : cctrans;
    assign ccw  = (&cctrans) ? dwin : cctrans[1];

    rr_arb2 u_rr_d (
        .CLK  (CLK),
        .nRST (nRST),
        .req  (darb),
        .adv  (dadv),
        .win  (dwin)
    );

    rr_arb2 u_rr_i (
        .CLK  (CLK),
        .nRST (nRST),
        .req  (iREN),
        .adv  (iadv),
        .win  (iwin)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            g        <= 1'b0;
            c2c_hold <= 1'b0;
        end else begin
            state    <= nstate;
            g        <= ng;
            c2c_hold <= nhold;
        end
    end

    always_comb begin
        nstate      = state;
        ng          = g;
        nhold       = c2c_hold;
        dadv        = 1'b0;
        iadv        = 1'b0;
        dwait       = '1;
        iwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        dload       = {NCORES{ramload}};

        if (state != IDLE && state != IFETCH) begin
            ccwait[o]      = 1'b1;
            ccsnoopaddr[o] = daddr[g];
        end

        unique case (state)
            IDLE: begin
                if (|cctrans) begin
                    ccwait[~ccw]      = 1'b1;
                    ccinv[~ccw]       = 1'b1;
                    ccsnoopaddr[~ccw] = daddr[ccw];
                end
                if (|dreq) begin
                    ng     = dwin;
                    nstate = dWEN[dwin] ? DWB : SNOOP;
                end else if (|iREN) begin
                    ng     = iwin;
                    nstate = IFETCH;
                end
            end
            DWB: begin
                if (!dWEN[g]) begin
                    nstate = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[g];
                    ramstore = dstore[g];
                    if (done) begin
                        dwait[g] = 1'b0;
                        dadv     = 1'b1;
                        nstate   = IDLE;
                    end
                end
            end
            SNOOP: begin
                if (!dREN[g]) begin
                    nstate = IDLE;
                end else begin
                    // Word 1 reuses the word-0 dirty decision.
                    nstate = (ccwrite[o] || c2c_hold) ? C2C : MEMRD;
                    if (ccwrite[o])
                        nhold = 1'b1;
                end
            end
            C2C: begin
                if (!dREN[g]) begin
                    nstate = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[g];
                    ramstore = dstore[o];
                    dload[g] = dstore[o];
                    if (done) begin
                        dwait[g] = 1'b0;
                        nstate   = IDLE;
                        if (lastw) begin
                            nhold = 1'b0;
                            dadv  = 1'b1;
                        end
                    end
                end
            end
            MEMRD: begin
                if (!dREN[g]) begin
                    nstate = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = daddr[g];
                    if (done) begin
                        dwait[g] = 1'b0;
                        dadv     = lastw;
                        nstate   = IDLE;
                    end
                end
            end
            IFETCH: begin
                if (!iREN[g]) begin
                    nstate = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[g];
                    if (done) begin
                        iwait[g] = 1'b0;
                        iadv     = 1'b1;
                        nstate   = IDLE;
                    end
                end
            end
            default: nstate = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed and random bench for coherence_bus_ctrl with a RAM
// model, snoop-responding cache models and a reference memory.
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    logic [1:0] iREN, iwait, dREN, dWEN, dwait;
    logic [1:0] cctrans, ccwrite, ccwait, ccinv;
    word_t [1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    word_t [1:0] drv_store;
    logic ramREN, ramWEN;
    word_t ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.NCORES(2), .OFFBIT(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    function automatic word_t init_val(input word_t a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // RAM: BUSY for lat cycles of a held strobe, then ACCESS.
    int unsigned lat = 0;
    int unsigned cnt = 0;
    int nwrites = 0;
    word_t wdat [1024];
    bit wv [1024];

    always_comb begin
        if (!(ramREN || ramWEN))
            ramstate = FREE;
        else
            ramstate = (cnt >= lat) ? ACCESS : BUSY;
    end

    assign ramload = wv[ramaddr[11:2]] ? wdat[ramaddr[11:2]]
                                       : init_val(ramaddr);

    always @(posedge CLK) begin
        if (ramREN || ramWEN) begin
            if (ramstate == ACCESS) begin
                cnt <= 0;
                if (ramWEN) begin
                    wdat[ramaddr[11:2]] <= ramstore;
                    wv[ramaddr[11:2]] <= 1'b1;
                    nwrites <= nwrites + 1;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    function automatic word_t ram_val(input word_t a);
        return wv[a[11:2]] ? wdat[a[11:2]] : init_val(a);
    endfunction

    // Cache snoop responders: a dirty copy drops dirty after ccwrite.
    word_t blk [2];
    word_t cdata [2][2];
    int dirty_tok [2] = '{0, 0};
    int wb_gen [2] = '{0, 0};
    logic [1:0] hit;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            hit[c] = ccsnoopaddr[c][31:3] == blk[c][31:3];
            ccwrite[c] = ccwait[c] && hit[c] &&
                         (dirty_tok[c] != wb_gen[c]);
            dstore[c] = ccwait[c] ? cdata[c][ccsnoopaddr[c][2]]
                                  : drv_store[c];
        end
    end

    always @(posedge CLK) begin
        for (int c = 0; c < 2; c++)
            if (ccwrite[c])
                wb_gen[c] <= wb_gen[c] + 1;
    end

    // Reference memory, updated from what each transaction means.
    word_t refm [int];

    function automatic word_t ref_val(input word_t a);
        return refm.exists(int'(a)) ? refm[int'(a)] : init_val(a);
    endfunction

    task automatic chk(input string tag, input word_t obs,
                       input word_t exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic dop(input int c, input bit wr, input word_t a,
                       input word_t d, output word_t got,
                       output int waits);
        daddr[c] = a;
        drv_store[c] = d;
        if (wr) dWEN[c] = 1'b1;
        else dREN[c] = 1'b1;
        waits = 0;
        got = 'x;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (dwait[c] === 1'b0) begin
                got = dload[c];
                break;
            end
            waits++;
        end
        chk("dtimeout", 32'(waits < 200), 32'd1);
        @(posedge CLK);
        #1;
        dREN[c] = 1'b0;
        dWEN[c] = 1'b0;
    endtask

    task automatic iop(input int c, input word_t a,
                       output word_t got, output int waits);
        iaddr[c] = a;
        iREN[c] = 1'b1;
        waits = 0;
        got = 'x;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (iwait[c] === 1'b0) begin
                got = iload[c];
                break;
            end
            waits++;
        end
        chk("itimeout", 32'(waits < 200), 32'd1);
        @(posedge CLK);
        #1;
        iREN[c] = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chk("rst dwait", 32'(dwait), 32'd3);
        chk("rst iwait", 32'(iwait), 32'd3);
        chk("rst ccwait", 32'(ccwait), 32'd0);
        chk("rst ccinv", 32'(ccinv), 32'd0);
        chk("rst ramstrb", 32'({ramREN, ramWEN}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        word_t got, g0a, g0b, g1a, g1b, d, A, B;
        int w, w0, w1, w2, w3, nw0, bad, op, c, o;
        time t01, t10, td, ti;
        word_t base, a;
        bit found;

        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0;
        iaddr = '0; daddr = '0; drv_store = '0;
        for (int k = 0; k < 2; k++) begin
            blk[k] = 32'hFFFF_FFF8;
            cdata[k][0] = '0;
            cdata[k][1] = '0;
        end
        @(negedge CLK);
        chk_reset_outs();
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Clean block read by core0.
        dop(0, 0, 32'h100, 0, got, w);
        chk("t1 w0", got, ref_val(32'h100));
        chk("t1 w0 waits", 32'(w), 32'd2);
        dop(0, 0, 32'h104, 0, got, w);
        chk("t1 w1", got, ref_val(32'h104));
        chk("t1 w1 waits", 32'(w), 32'd2);
        chk("t1 no ram wr", 32'(nwrites), 32'd0);

        // Double write hit with rr_d = 1: core1 invalidates core0.
        cctrans = 2'b11;
        daddr[0] = 32'h300;
        daddr[1] = 32'h300;
        @(negedge CLK);
        chk("t4 ccinv", 32'(ccinv), 32'd1);
        chk("t4 ccwait", 32'(ccwait), 32'd1);
        chk("t4 snoop0", ccsnoopaddr[0], 32'h300);
        @(posedge CLK);
        #1;
        cctrans = 2'b01;
        daddr[0] = 32'h308;
        @(negedge CLK);
        chk("t4 one ccinv", 32'(ccinv), 32'd2);
        chk("t4 one ccwait", 32'(ccwait), 32'd2);
        chk("t4 one snoop1", ccsnoopaddr[1], 32'h308);
        @(posedge CLK);
        #1 cctrans = '0;

        // Dirty block in core1 forwarded to core0.
        A = $urandom;
        B = $urandom;
        blk[1] = 32'h200;
        cdata[1][0] = A;
        cdata[1][1] = B;
        dirty_tok[1] = wb_gen[1] + 1;
        nw0 = nwrites;
        dop(0, 0, 32'h200, 0, got, w);
        chk("t2 w0", got, A);
        chk("t2 w0 waits", 32'(w), 32'd2);
        dop(0, 0, 32'h204, 0, got, w);
        chk("t2 w1", got, B);
        chk("t2 ram A", ram_val(32'h200), A);
        chk("t2 ram B", ram_val(32'h204), B);
        chk("t2 nwr", 32'(nwrites - nw0), 32'd2);
        refm[32'h200] = A;
        refm[32'h204] = B;
        dirty_tok[1] = wb_gen[1];

        // Contended block reads; rr_d = 0 so core0 goes first.
        lat = 1;
        t01 = 0;
        t10 = 0;
        fork
            begin
                dop(0, 0, 32'h400, 0, g0a, w0);
                dop(0, 0, 32'h404, 0, g0b, w1);
                t01 = $time;
            end
            begin
                dop(1, 0, 32'h500, 0, g1a, w2);
                t10 = $time;
                dop(1, 0, 32'h504, 0, g1b, w3);
            end
        join
        chk("t3 c0w0", g0a, ref_val(32'h400));
        chk("t3 c0w1", g0b, ref_val(32'h404));
        chk("t3 c1w0", g1a, ref_val(32'h500));
        chk("t3 c1w1", g1b, ref_val(32'h504));
        chk("t3 order", 32'(t01 < t10), 32'd1);

        // Pending write-back beats a pending instruction fetch.
        lat = 0;
        d = $urandom;
        td = 0;
        ti = 0;
        fork
            begin
                dop(1, 1, 32'h600, d, got, w);
                td = $time;
            end
            begin
                iop(0, 32'h700, g0a, w1);
                ti = $time;
            end
            begin
                found = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge CLK);
                    if (ramWEN === 1'b1) begin
                        found = 1'b1;
                        chk("t5 ramstore", ramstore, d);
                        chk("t5 ramaddr", ramaddr, 32'h600);
                        break;
                    end
                end
                chk("t5 dwb seen", 32'(found), 32'd1);
            end
        join
        refm[32'h600] = d;
        chk("t5 order", 32'(td < ti), 32'd1);
        chk("t5 iload", g0a, ref_val(32'h700));
        chk("t5 ram", ram_val(32'h600), d);
        @(negedge CLK);
        chk("t5 iwait back", 32'(iwait), 32'd3);
        @(posedge CLK);
        #1;

        // Slow RAM: three BUSY cycles stretch the read.
        lat = 3;
        dop(0, 0, 32'h800, 0, got, w);
        chk("t6 busy data", got, ref_val(32'h800));
        chk("t6 busy waits", 32'(w), 32'd5);

        // Reset in the middle of a cache-to-cache transfer.
        lat = 5;
        blk[1] = 32'h900;
        cdata[1][0] = $urandom;
        cdata[1][1] = ~ref_val(32'h904);
        dirty_tok[1] = wb_gen[1] + 1;
        nw0 = nwrites;
        daddr[0] = 32'h900;
        dREN[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (ramWEN === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6 c2c seen", 32'(found), 32'd1);
        nRST = 1'b0;
        dREN[0] = 1'b0;
        #1;
        chk_reset_outs();
        @(posedge CLK);
        #1 nRST = 1'b1;
        lat = 0;
        dirty_tok[1] = wb_gen[1];
        dop(0, 0, 32'h904, 0, got, w);
        chk("t6 hold clr", got, ref_val(32'h904));
        chk("t6 no wr", 32'(nwrites - nw0), 32'd0);

        // Random single-core traffic against the reference memory.
        for (int n = 0; n < 40; n++) begin
            lat = $urandom_range(0, 3);
            op = $urandom_range(0, 2);
            c = $urandom_range(0, 1);
            o = 1 - c;
            base = word_t'($urandom_range(0, 511)) << 3;
            dirty_tok[0] = wb_gen[0];
            dirty_tok[1] = wb_gen[1];
            if (op == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    blk[o] = base;
                    cdata[o][0] = $urandom;
                    cdata[o][1] = $urandom;
                    dirty_tok[o] = wb_gen[o] + 1;
                    refm[int'(base)] = cdata[o][0];
                    refm[int'(base + 4)] = cdata[o][1];
                end
                dop(c, 0, base, 0, got, w);
                chk("rnd rd0", got, ref_val(base));
                chk("rnd rd0 waits", 32'(w), 32'(2 + lat));
                dop(c, 0, base + 4, 0, got, w);
                chk("rnd rd1", got, ref_val(base + 4));
                chk("rnd rd1 waits", 32'(w), 32'(2 + lat));
            end else if (op == 1) begin
                a = base + (word_t'($urandom_range(0, 1)) << 2);
                d = $urandom;
                dop(c, 1, a, d, got, w);
                refm[int'(a)] = d;
                chk("rnd wr waits", 32'(w), 32'(1 + lat));
            end else begin
                a = base + (word_t'($urandom_range(0, 1)) << 2);
                iop(c, a, got, w);
                chk("rnd if", got, ref_val(a));
                chk("rnd if waits", 32'(w), 32'(1 + lat));
            end
        end
        dirty_tok[0] = wb_gen[0];
        dirty_tok[1] = wb_gen[1];

        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (ram_val(word_t'(k) << 2) !== ref_val(word_t'(k) << 2))
                bad++;
        chk("final ram image", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
